// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage and its neighbours:
//   - fetch FSM state encodings (IDLE / FETCH / HOLD / FAULT)
//   - RV32I major opcodes that select an immediate format
//   - immediate-select codes, shared with the immediate generator
//   - canonical NOP encoding (addi x0, x0, 0)
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_SEL_I    = 2'b00;
    localparam logic [1:0] IMM_SEL_S    = 2'b01;
    localparam logic [1:0] IMM_SEL_B    = 2'b10;
    localparam logic [1:0] IMM_SEL_ZERO = 2'b11;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

endpackage

// File: rtl/imm_sel_decode.sv
// ----------------------------------------------------------------------------
// imm_sel_decode
// Combinational pre-decode of the major opcode into the immediate generator's
// format select.
// Ports:
//   opcode_i   [6:0]  instruction bits [6:0]
//   imm_sel_o  [1:0]  00 I-type, 01 S-type, 10 B-type, 11 zero immediate
// ----------------------------------------------------------------------------
module imm_sel_decode
    import fetch_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [1:0] imm_sel_o
);

    always_comb begin
        imm_sel_o = IMM_SEL_ZERO;
        case (opcode_i)
            OP_IMM, OP_LOAD, OP_JALR: imm_sel_o = IMM_SEL_I;
            OP_STORE:                 imm_sel_o = IMM_SEL_S;
            OP_BRANCH:                imm_sel_o = IMM_SEL_B;
            default:                  imm_sel_o = IMM_SEL_ZERO;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: holds the PC, fetches one 32-bit word per request
// over a req/ready handshake and hands it to decode over valid/ready, together
// with its PC and a pre-decoded immediate select. Redirects (branch/jump) load
// pc = redirect_pc + redirect_imm and take priority over everything else.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect target with [1:0] != 0 enters a sticky FAULT state
//               (fetch_fault=1, no further requests, redirects ignored).
//   undefined : redirect target bits [1:0] are forced to 00; fetch_fault=0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req / imem_addr         fetch request and address (= pc)
//   imem_ready / imem_rdata      memory accept + returned instruction word
//   if_valid / if_ready          handshake to decode
//   if_instr / if_pc / if_imm_sel  instruction, its PC, immediate select
//   redirect_valid/_pc/_imm      redirect request, base PC and immediate
//   fetch_fault                  misaligned redirect fault (sticky)
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [1:0]  if_imm_sel,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] redirect_imm,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [1:0]   if_imm_sel_q, if_imm_sel_d;
    logic [1:0]   dec_sel;
    logic [31:0]  target;
    logic [31:0]  redirect_tgt;
    logic         redirect_take;
    logic         misalign;

    imm_sel_decode u_imm_sel_decode (
        .opcode_i  (imem_rdata[6:0]),
        .imm_sel_o (dec_sel)
    );

    // Carry out of the add is discarded: targets wrap modulo 2^32.
    assign target = redirect_pc + redirect_imm;

    // FAULT swallows redirects; only reset leaves it.
    assign redirect_take = redirect_valid && (state_q != FAULT);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign misalign     = (target[1:0] != 2'b00);
    assign redirect_tgt = target;
    assign fetch_fault  = fault_q;
`else
    assign misalign     = 1'b0;
    assign redirect_tgt = target & ~32'h0000_0003;
    assign fetch_fault  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect_take) begin
            state_d = misalign ? FAULT : FETCH;
        end else begin
            case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   if (imem_ready) state_d = HOLD;
                HOLD:    if (if_ready)   state_d = FETCH;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: request is a pure decode of the registered state, so an
    // asynchronous reset drops it immediately.
    always_comb begin
        imem_req = (state_q == FETCH);
    end

    // Datapath next-state
    always_comb begin
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_imm_sel_d = if_imm_sel_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d      = fault_q;
`endif
        if (redirect_take) begin
            // Any same-cycle memory data or decode handshake is cancelled.
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign) begin
                fault_d = 1'b1;
            end else begin
                pc_d = redirect_tgt;
            end
`else
            pc_d = redirect_tgt;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        if_instr_d   = imem_rdata;
                        if_pc_d      = pc_q;
                        if_imm_sel_d = dec_sel;
                        if_valid_d   = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        if_valid_d = 1'b0;
                        if_instr_d = NOP_INSTR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= NOP_INSTR;
            if_pc_q      <= 32'h0000_0000;
            if_imm_sel_q <= IMM_SEL_ZERO;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_imm_sel_q <= if_imm_sel_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign imem_addr  = pc_q;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_imm_sel = if_imm_sel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage. Each table row gives the
// inputs held across one rising edge and the outputs expected just after it.
// Follows FETCH_MISALIGN_TRAP_EN if defined for the build.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [1:0]  if_imm_sel;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] redirect_imm = 32'h0;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_imm_sel     (if_imm_sel),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_imm   (redirect_imm),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic [31:0] rdata;
        logic        ifr;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] rimm;
        logic        e_req;
        logic [31:0] e_addr;
        logic        chk_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [1:0]  e_sel;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ready, input logic [31:0] rdata, input logic ifr,
                       input logic rv, input logic [31:0] rpc, input logic [31:0] rimm,
                       input logic e_req, input logic [31:0] e_addr, input logic chk_addr,
                       input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic [1:0] e_sel, input logic e_fault);
        vec_t v;
        v.ready = ready; v.rdata = rdata; v.ifr = ifr; v.rv = rv; v.rpc = rpc; v.rimm = rimm;
        v.e_req = e_req; v.e_addr = e_addr; v.chk_addr = chk_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_sel = e_sel; v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   {31'h0, imem_req},    32'h0);
        check({tag, "_addr"},  imem_addr,            32'h0);
        check({tag, "_valid"}, {31'h0, if_valid},    32'h0);
        check({tag, "_instr"}, if_instr,             NOP);
        check({tag, "_pc"},    if_pc,                32'h0);
        check({tag, "_sel"},   {30'h0, if_imm_sel},  32'h3);
        check({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
    endtask

    initial begin
        // ready rdata ifr | rv rpc rimm | req addr chk | valid instr pc sel | fault
        add(1, 32'h00500093, 1, 0, 0, 0,            1, 32'h0,  1, 0, NOP,          0, 0, 0); // IDLE -> FETCH
        add(1, 32'h00500093, 1, 0, 0, 0,            0, 32'h4,  1, 1, 32'h00500093, 0, 0, 0); // capture addi
        for (int i = 0; i < 5; i++)
            add(1, 32'hDEADBEEF, 0, 0, 0, 0,        0, 32'h4,  1, 1, 32'h00500093, 0, 0, 0); // decode stalls
        add(1, 32'hDEADBEEF, 1, 0, 0, 0,            1, 32'h4,  1, 0, NOP,          0, 0, 0); // handshake
        add(1, 32'hFE208EE3, 1, 0, 0, 0,            0, 32'h8,  1, 1, 32'hFE208EE3, 32'h4, 2, 0); // branch
        add(0, 32'h0,        1, 0, 0, 0,            1, 32'h8,  1, 0, NOP,          0, 0, 0);
        add(0, 32'h0,        1, 0, 0, 0,            1, 32'h8,  1, 0, NOP,          0, 0, 0); // wait state
        add(1, 32'h00112223, 1, 0, 0, 0,            0, 32'hC,  1, 1, 32'h00112223, 32'h8, 1, 0); // sw
        add(0, 32'h0,        1, 0, 0, 0,            1, 32'hC,  1, 0, NOP,          0, 0, 0);
        add(1, 32'h000000B7, 1, 0, 0, 0,            0, 32'h10, 1, 1, 32'h000000B7, 32'hC, 3, 0); // lui
        add(0, 32'h0,        1, 0, 0, 0,            1, 32'h10, 1, 0, NOP,          0, 0, 0);
        // redirect same cycle as imem_ready: 0x100 + (-8) = 0xF8, data dropped
        add(1, 32'h00500093, 1, 1, 32'h100, 32'hFFFFFFF8, 1, 32'hF8, 1, 0, NOP,   0, 0, 0);
        add(0, 32'h0,        1, 0, 0, 0,            1, 32'hF8, 1, 0, NOP,          0, 0, 0);
        // wrap: fetch at 0xFFFFFFFC, pc becomes 0
        add(0, 32'h0,        1, 1, 32'h0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 0, NOP, 0, 0, 0);
        add(1, 32'h00112223, 0, 0, 0, 0,            0, 32'h0,  1, 1, 32'h00112223, 32'hFFFFFFFC, 1, 0);
        // redirect in HOLD cancels the same-cycle decode handshake
        add(0, 32'h0,        1, 1, 32'h200, 32'h10, 1, 32'h210, 1, 0, NOP,         0, 0, 0);
        // back-to-back redirects: last one wins
        add(1, 32'h00500093, 1, 1, 32'h300, 32'h0,  1, 32'h300, 1, 0, NOP,         0, 0, 0);
        add(1, 32'h00500093, 1, 1, 32'h400, 32'h4,  1, 32'h404, 1, 0, NOP,         0, 0, 0);
        add(1, 32'h00500093, 0, 0, 0, 0,            0, 32'h408, 1, 1, 32'h00500093, 32'h404, 0, 0);
        add(0, 32'h0,        1, 0, 0, 0,            1, 32'h408, 1, 0, NOP,         0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        add(1, 32'h00500093, 1, 1, 32'h100, 32'h2,  0, 32'h0,  0, 0, NOP,          0, 0, 1); // -> FAULT
        add(1, 32'h00112223, 1, 1, 32'h0, 32'h20,   0, 32'h0,  0, 0, NOP,          0, 0, 1); // ignored
        add(1, 32'h00112223, 1, 0, 0, 0,            0, 32'h0,  0, 0, NOP,          0, 0, 1);
`else
        add(1, 32'h00500093, 1, 1, 32'h100, 32'h2,  1, 32'h100, 1, 0, NOP,         0, 0, 0); // low bits cleared
        add(1, 32'h00112223, 1, 1, 32'h0, 32'h20,   1, 32'h20, 1, 0, NOP,          0, 0, 0);
        add(1, 32'h00112223, 1, 0, 0, 0,            0, 32'h24, 1, 1, 32'h00112223, 32'h20, 1, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            imem_ready     = vecs[i].ready;
            imem_rdata     = vecs[i].rdata;
            if_ready       = vecs[i].ifr;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            redirect_imm   = vecs[i].rimm;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_req", i),   {31'h0, imem_req},    {31'h0, vecs[i].e_req});
            if (vecs[i].chk_addr)
                check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'h0, if_valid},    {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d_instr", i), if_instr,             vecs[i].e_instr);
            check($sformatf("v%0d_fault", i), {31'h0, fetch_fault}, {31'h0, vecs[i].e_fault});
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i),  if_pc,               vecs[i].e_pc);
                check($sformatf("v%0d_sel", i), {30'h0, if_imm_sel}, {30'h0, vecs[i].e_sel});
            end
            @(negedge clk);
        end

        // Reset from HOLD/FAULT clears everything, including a sticky fault.
        imem_ready = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("rst_async");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("bubble_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        check("refetch_req", {31'h0, imem_req}, 32'h1);
        check("refetch_addr", imem_addr, 32'h0);

        // Reset mid-fetch: request drops without waiting for a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("midfetch_req", {31'h0, imem_req}, 32'h0);
        check("midfetch_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h00500093;
        if_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_valid", {31'h0, if_valid}, 32'h1);
        check("post_rst_instr", if_instr, 32'h00500093);
        check("post_rst_addr", imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
